biquad_coeff_ctrl: RTL and testbench

- Coefficient manager and sequencer for a cascade of NUM_SECT biquad sections in the hydrophone filter chain.
- Host register interface (SPI/USB bridge) writes a shadow coefficient bank; on commit the controller swaps banks at a sample boundary, flushes the biquad state, and resynchronises the shadow bank.
- Drives every section's b0, b1, b2, NEGa1, NEGa2 and its reset input.

---
 rtl/biquad_pkg.sv | 44 ++++
 rtl/biquad_coeff_ctrl_if.sv | 34 +++
 rtl/biquad_coeff_bank.sv | 62 ++++++
 rtl/biquad_coeff_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_biquad_coeff_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/biquad_pkg.sv
// -----------------------------------------------------------------------------
// biquad_pkg
// Shared constants and types for the biquad coefficient controller:
//   - coefficient index map within one section (b0, b1, b2, NEGa1, NEGa2)
//   - Q-format constants (Q(COEFF_W-16).16, 1.0 = ONE_Q)
//   - controller FSM state encoding
//   - small helpers for address legality and passthrough reset values
// -----------------------------------------------------------------------------
package biquad_pkg;

    localparam int IDX_B0    = 0;
    localparam int IDX_B1    = 1;
    localparam int IDX_B2    = 2;
    localparam int IDX_NA1   = 3;
    localparam int IDX_NA2   = 4;
    localparam int NUM_COEFF = 5;

    localparam int FRAC_BITS = 16;
    localparam int ONE_Q     = 65536;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        FLUSH     = 2'd2,
        COPY      = 2'd3
    } state_e;

    // Coefficient index field is 3 bits wide; only 0..4 map to real words.
    function automatic logic idx_legal(input logic [2:0] idx);
        return (idx < 3'(NUM_COEFF));
    endfunction

    // Passthrough filter: b0 = 1.0, everything else 0.
    function automatic int passthrough_val(input int word_idx);
        int val;
        if ((word_idx % NUM_COEFF) == IDX_B0) begin
            val = ONE_Q;
        end else begin
            val = 0;
        end
        return val;
    endfunction

endpackage

// File: rtl/biquad_coeff_ctrl_if.sv
// -----------------------------------------------------------------------------
// biquad_coeff_ctrl_if
// Host write channel into the coefficient controller (valid/ready handshake).
//   wrValid_i : host write request
//   wrReady_o : controller accepts the write this cycle
//   wrAddr_i  : {section, coeffIdx}, coeffIdx in the low 3 bits
//   wrData_i  : signed coefficient, stored verbatim
// Modports: master = host side, slave = controller side.
// -----------------------------------------------------------------------------
interface biquad_coeff_ctrl_if #(
    parameter int NUM_SECT = 4,
    parameter int COEFF_W  = 18
);
    localparam int ADDR_W = 3 + $clog2(NUM_SECT);

    logic               wrValid_i;
    logic               wrReady_o;
    logic [ADDR_W-1:0]  wrAddr_i;
    logic [COEFF_W-1:0] wrData_i;

    modport master (
        output wrValid_i,
        output wrAddr_i,
        output wrData_i,
        input  wrReady_o
    );

    modport slave (
        input  wrValid_i,
        input  wrAddr_i,
        input  wrData_i,
        output wrReady_o
    );
endinterface

// File: rtl/biquad_coeff_bank.sv
// -----------------------------------------------------------------------------
// biquad_coeff_bank
// One bank of NUM_SECT x 5 coefficient words.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, loads passthrough (b0 = 1.0)
//   we_i     : write enable
//   waddr_i  : flat word index, section*5 + coeffIdx
//   wdata_i  : word to store
//   rdata_o  : all words, flat; word w at [w*COEFF_W +: COEFF_W]
// -----------------------------------------------------------------------------
module biquad_coeff_bank
    import biquad_pkg::*;
#(
    parameter  int NUM_SECT = 4,
    parameter  int COEFF_W  = 18,
    localparam int NW       = NUM_SECT * NUM_COEFF,
    localparam int WIDX_W   = $clog2(NW)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [WIDX_W-1:0]     waddr_i,
    input  logic [COEFF_W-1:0]    wdata_i,
    output logic [NW*COEFF_W-1:0] rdata_o
);

    logic [COEFF_W-1:0] mem_q [NW];
    logic [COEFF_W-1:0] mem_d [NW];

    // Next-state of every word: only the addressed word takes the write data.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            if (we_i && (waddr_i == WIDX_W'(i))) begin
                mem_d[i] = wdata_i;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Word storage with synchronous passthrough reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NW; i++) begin
                mem_q[i] <= COEFF_W'(passthrough_val(i));
            end
        end else begin
            for (int i = 0; i < NW; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Flatten the bank onto the read bus.
    always_comb begin
        rdata_o = {(NW*COEFF_W){1'b0}};
        for (int i = 0; i < NW; i++) begin
            rdata_o[i*COEFF_W +: COEFF_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/biquad_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// biquad_coeff_ctrl
// Coefficient manager for a cascade of NUM_SECT biquad sections. The host
// writes a shadow bank; a commit waits for the next sample tick, swaps banks,
// holds the biquads in reset for FLUSH_CYCLES, then copies active -> shadow
// one word per cycle so the shadow matches the new active set.
// Ports:
//   IIRclk_i      : clock
//   modeReset_i   : synchronous active-high reset
//   sampleTick_i  : sample boundary pulse
//   wr_if         : host write channel (slave modport)
//   commit_i      : request shadow -> active swap
//   busy_o        : commit sequence in progress
//   commitDone_o  : one-cycle pulse when the sequence completes
//   addrErr_o     : sticky illegal-write-address flag
//   biquadReset_o : reset to the biquad sections
//   coeff_o       : active coefficients, section s idx k at (5s+k)*COEFF_W
// Optional build macro BIQUAD_COEFF_READBACK_EN adds a registered read port:
//   rdEn_i, rdAddr_i, rdSel_i (0 shadow / 1 active), rdData_o, rdValid_o
// -----------------------------------------------------------------------------
module biquad_coeff_ctrl
    import biquad_pkg::*;
#(
    parameter  int NUM_SECT     = 4,
    parameter  int COEFF_W      = 18,
    parameter  int FLUSH_CYCLES = 4,
    localparam int ADDR_W       = 3 + $clog2(NUM_SECT),
    localparam int NW           = NUM_SECT * NUM_COEFF,
    localparam int WIDX_W       = $clog2(NW),
    localparam int BUS_W        = NW * COEFF_W
) (
    input  logic                 IIRclk_i,
    input  logic                 modeReset_i,
    input  logic                 sampleTick_i,
    biquad_coeff_ctrl_if.slave   wr_if,
    input  logic                 commit_i,
    output logic                 busy_o,
    output logic                 commitDone_o,
    output logic                 addrErr_o,
    output logic                 biquadReset_o,
    output logic [BUS_W-1:0]     coeff_o
`ifdef BIQUAD_COEFF_READBACK_EN
    ,
    input  logic                 rdEn_i,
    input  logic [ADDR_W-1:0]    rdAddr_i,
    input  logic                 rdSel_i,
    output logic [COEFF_W-1:0]   rdData_o,
    output logic                 rdValid_o
`endif
);

    state_e              state_q, state_d;
    logic                bank_sel_q, bank_sel_d;
    logic [3:0]          flush_cnt_q, flush_cnt_d;
    logic [WIDX_W-1:0]   copy_idx_q, copy_idx_d;
    logic                wr_ready_q, wr_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                addr_err_q, addr_err_d;
    logic                bq_rst_q, bq_rst_d;

    logic [BUS_W-1:0]    bus0_s, bus1_s, active_bus_s;
    logic [ADDR_W-1:0]   wr_sect_s;
    logic                wr_fire_s, wr_legal_s;
    logic [WIDX_W-1:0]   wr_word_s;
    logic                shd_we_s, we0_s, we1_s;
    logic [WIDX_W-1:0]   shd_addr_s;
    logic [COEFF_W-1:0]  shd_data_s, copy_word_s;

    biquad_coeff_bank #(.NUM_SECT(NUM_SECT), .COEFF_W(COEFF_W)) u_bank0 (
        .clk_i   (IIRclk_i),
        .rst_i   (modeReset_i),
        .we_i    (we0_s),
        .waddr_i (shd_addr_s),
        .wdata_i (shd_data_s),
        .rdata_o (bus0_s)
    );

    biquad_coeff_bank #(.NUM_SECT(NUM_SECT), .COEFF_W(COEFF_W)) u_bank1 (
        .clk_i   (IIRclk_i),
        .rst_i   (modeReset_i),
        .we_i    (we1_s),
        .waddr_i (shd_addr_s),
        .wdata_i (shd_data_s),
        .rdata_o (bus1_s)
    );

    // Host address decode: legality and flat word index.
    always_comb begin
        wr_sect_s  = wr_if.wrAddr_i >> 3;
        wr_legal_s = idx_legal(wr_if.wrAddr_i[2:0]) && (wr_sect_s < ADDR_W'(NUM_SECT));
        wr_word_s  = WIDX_W'(int'(wr_sect_s) * NUM_COEFF + int'(wr_if.wrAddr_i[2:0]));
        wr_fire_s  = wr_if.wrValid_i & wr_ready_q;
    end

    // Active bank select and the word currently being copied.
    always_comb begin
        if (bank_sel_q) begin
            active_bus_s = bus1_s;
        end else begin
            active_bus_s = bus0_s;
        end
        copy_word_s = active_bus_s[int'(copy_idx_q)*COEFF_W +: COEFF_W];
    end

    // Shadow write port: COPY owns it, otherwise accepted legal host writes.
    // Host writes only land in IDLE, so the two sources never collide.
    always_comb begin
        if (state_q == COPY) begin
            shd_we_s   = 1'b1;
            shd_addr_s = copy_idx_q;
            shd_data_s = copy_word_s;
        end else begin
            shd_we_s   = wr_fire_s & wr_legal_s;
            shd_addr_s = wr_word_s;
            shd_data_s = wr_if.wrData_i;
        end
        we0_s = shd_we_s & bank_sel_q;
        we1_s = shd_we_s & ~bank_sel_q;
    end

    // Commit sequencer next-state and registered output values.
    always_comb begin
        state_d     = state_q;
        bank_sel_d  = bank_sel_q;
        flush_cnt_d = flush_cnt_q;
        copy_idx_d  = copy_idx_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_i) begin
                    state_d = WAIT_TICK;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_TICK: begin
                if (sampleTick_i) begin
                    bank_sel_d  = ~bank_sel_q;
                    flush_cnt_d = 4'(FLUSH_CYCLES - 1);
                    state_d     = FLUSH;
                end else begin
                    state_d = WAIT_TICK;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    copy_idx_d = {WIDX_W{1'b0}};
                    state_d    = COPY;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            COPY: begin
                if (copy_idx_q == WIDX_W'(NW - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    copy_idx_d = copy_idx_q + WIDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wr_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        bq_rst_d   = (state_d == FLUSH);
        addr_err_d = addr_err_q | (wr_fire_s & ~wr_legal_s);
    end

    // Controller state registers.
    always_ff @(posedge IIRclk_i) begin
        if (modeReset_i) begin
            state_q     <= IDLE;
            bank_sel_q  <= 1'b0;
            flush_cnt_q <= 4'd0;
            copy_idx_q  <= {WIDX_W{1'b0}};
            wr_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_err_q  <= 1'b0;
            bq_rst_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_sel_q  <= bank_sel_d;
            flush_cnt_q <= flush_cnt_d;
            copy_idx_q  <= copy_idx_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_err_q  <= addr_err_d;
            bq_rst_q    <= bq_rst_d;
        end
    end

    // The biquads must see reset in the same cycle modeReset_i is high,
    // so the mode reset is ORed in directly rather than through the flop.
    assign biquadReset_o   = modeReset_i | bq_rst_q;
    assign wr_if.wrReady_o = wr_ready_q;
    assign busy_o          = busy_q;
    assign commitDone_o    = done_q;
    assign addrErr_o       = addr_err_q;
    assign coeff_o         = active_bus_s;

`ifdef BIQUAD_COEFF_READBACK_EN
    logic [COEFF_W-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]  rd_sect_s;
    logic [WIDX_W-1:0]  rd_word_s;
    logic               rd_legal_s;
    logic [BUS_W-1:0]   rd_src_s;

    // Read decode; an illegal read address returns zero and is not flagged.
    always_comb begin
        rd_sect_s  = rdAddr_i >> 3;
        rd_legal_s = idx_legal(rdAddr_i[2:0]) && (rd_sect_s < ADDR_W'(NUM_SECT));
        rd_word_s  = WIDX_W'(int'(rd_sect_s) * NUM_COEFF + int'(rdAddr_i[2:0]));
        if (rdSel_i) begin
            rd_src_s = active_bus_s;
        end else if (bank_sel_q) begin
            rd_src_s = bus0_s;
        end else begin
            rd_src_s = bus1_s;
        end
        rd_valid_d = rdEn_i;
        if (rdEn_i && rd_legal_s) begin
            rd_data_d = rd_src_s[int'(rd_word_s)*COEFF_W +: COEFF_W];
        end else begin
            rd_data_d = {COEFF_W{1'b0}};
        end
    end

    // Registered read port.
    always_ff @(posedge IIRclk_i) begin
        if (modeReset_i) begin
            rd_data_q  <= {COEFF_W{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rdData_o  = rd_data_q;
    assign rdValid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_biquad_coeff_ctrl.sv
// -----------------------------------------------------------------------------
// tb_biquad_coeff_ctrl
// Directed bench for biquad_coeff_ctrl (NUM_SECT=4, COEFF_W=18, FLUSH_CYCLES=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A small two-bank model (exp_act / exp_shd) holds expectations.
// -----------------------------------------------------------------------------
module tb_biquad_coeff_ctrl;
    import biquad_pkg::*;

    localparam int NUM_SECT     = 4;
    localparam int COEFF_W      = 18;
    localparam int FLUSH_CYCLES = 4;
    localparam int NW           = NUM_SECT * NUM_COEFF;
    localparam int ADDR_W       = 3 + $clog2(NUM_SECT);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, tick, commit;
    logic                    busy, done, aerr, bqrst;
    logic [NW*COEFF_W-1:0]   coeff;

    biquad_coeff_ctrl_if #(.NUM_SECT(NUM_SECT), .COEFF_W(COEFF_W)) wr_if ();

`ifdef BIQUAD_COEFF_READBACK_EN
    logic [COEFF_W-1:0] rd_data;
    logic               rd_valid;
`endif

    biquad_coeff_ctrl #(
        .NUM_SECT(NUM_SECT), .COEFF_W(COEFF_W), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .IIRclk_i      (clk),
        .modeReset_i   (rst),
        .sampleTick_i  (tick),
        .wr_if         (wr_if),
        .commit_i      (commit),
        .busy_o        (busy),
        .commitDone_o  (done),
        .addrErr_o     (aerr),
        .biquadReset_o (bqrst),
        .coeff_o       (coeff)
`ifdef BIQUAD_COEFF_READBACK_EN
        ,
        .rdEn_i        (1'b0),
        .rdAddr_i      ({ADDR_W{1'b0}}),
        .rdSel_i       (1'b0),
        .rdData_o      (rd_data),
        .rdValid_o     (rd_valid)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic signed [COEFF_W-1:0] exp_act [NW];
    logic signed [COEFF_W-1:0] exp_shd [NW];

    typedef struct {
        int                        sect;
        int                        idx;
        logic signed [COEFF_W-1:0] data;
        logic                      exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [COEFF_W-1:0] word(input int i);
        return coeff[i*COEFF_W +: COEFF_W];
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string nm);
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("%s w%0d", nm, i), word(i), exp_act[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            exp_act[i] = (i % NUM_COEFF == 0) ? COEFF_W'(ONE_Q) : {COEFF_W{1'b0}};
            exp_shd[i] = exp_act[i];
        end
    endtask

    task automatic wr(input int s, input int k, input logic [COEFF_W-1:0] d);
        wr_if.wrValid_i = 1'b1;
        wr_if.wrAddr_i  = ADDR_W'(s * 8 + k);
        wr_if.wrData_i  = d;
        next();
        wr_if.wrValid_i = 1'b0;
    endtask

    // Commit with the tick tick_at cycles later; done must land at the
    // cycle the latency formula gives. Bounded so the bench always ends.
    task automatic run_commit(input int tick_at, input string nm);
        int seen;
        seen = -1;
        for (int c = 0; c < 100 && seen < 0; c++) begin
            commit = (c == 0);
            tick   = (c == tick_at);
            @(negedge clk);
            if (done) seen = c;
            next();
        end
        commit = 1'b0;
        tick   = 1'b0;
        chk({nm, " done cycle"}, seen, tick_at + 1 + FLUSH_CYCLES + NW);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; commit = 1'b0;
        wr_if.wrValid_i = 1'b0;
        wr_if.wrAddr_i  = {ADDR_W{1'b0}};
        wr_if.wrData_i  = {COEFF_W{1'b0}};
        model_reset();

        tbl[0] = '{0, 0, 18'sd1000,   1'b0};
        tbl[1] = '{3, 4, -18'sd5,     1'b0};
        tbl[2] = '{0, 6, 18'sd555,    1'b1};
        tbl[3] = '{2, 3, 18'h1FFFF,   1'b1};
        tbl[4] = '{0, 1, 18'h20000,   1'b1};
        tbl[5] = '{1, 5, 18'sd42,     1'b1};
        tbl[6] = '{3, 7, 18'sd9,      1'b1};
        tbl[7] = '{2, 0, 18'sd32768,  1'b1};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst biquadReset", bqrst, 1);
        chk("rst wrReady", wr_if.wrReady_o, 1);
        chk("rst busy", busy, 0);
        check_all("rst");
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst biquadReset", bqrst, 0);
        chk("post-rst wrReady", wr_if.wrReady_o, 1);
        chk("post-rst busy", busy, 0);
        chk("post-rst done", done, 0);
        chk("post-rst addrErr", aerr, 0);
        next();

        // ---- s1.b2 = -1234, commit at c0, ticks at c0 (ignored) and c5 ----
        wr(1, 2, -18'sd1234);
        for (int c = 0; c <= 34; c++) begin
            commit = (c == 0);
            tick   = (c == 0) || (c == 5) || (c == 12);
            @(negedge clk);
            chk($sformatf("seq1 c%0d s1b2", c), word(7), (c >= 6) ? -1234 : 0);
            chk($sformatf("seq1 c%0d biquadReset", c), bqrst, (c >= 6 && c <= 9) ? 1 : 0);
            chk($sformatf("seq1 c%0d done", c), done, (c == 30) ? 1 : 0);
            chk($sformatf("seq1 c%0d busy", c), busy, (c >= 1 && c <= 29) ? 1 : 0);
            chk($sformatf("seq1 c%0d wrReady", c), wr_if.wrReady_o, (c >= 1 && c <= 29) ? 0 : 1);
            next();
        end
        commit = 1'b0; tick = 1'b0;
        exp_act[7] = -18'sd1234;
        exp_shd[7] = -18'sd1234;
        check_all("seq1 final");

        // ---- table of writes: legal ones land in shadow, illegal set addrErr ----
        for (int i = 0; i < 8; i++) begin
            int w;
            w = tbl[i].sect * NUM_COEFF + tbl[i].idx;
            wr(tbl[i].sect, tbl[i].idx, tbl[i].data);
            if (tbl[i].idx < NUM_COEFF) exp_shd[w] = tbl[i].data;
            @(negedge clk);
            chk($sformatf("tbl%0d addrErr", i), aerr, tbl[i].exp_err);
            if (tbl[i].idx < NUM_COEFF) begin
                chk($sformatf("tbl%0d active held", i), word(w), exp_act[w]);
            end
            next();
        end
        run_commit(3, "tbl");
        for (int i = 0; i < NW; i++) exp_act[i] = exp_shd[i];
        check_all("tbl commit");
        chk("tbl addrErr sticky", aerr, 1);

        // ---- write+commit same cycle, tick at c1, re-commit in COPY ignored ----
        for (int c = 0; c <= 40; c++) begin
            wr_if.wrValid_i = (c == 0);
            wr_if.wrAddr_i  = {ADDR_W{1'b0}};
            wr_if.wrData_i  = 18'sd777;
            commit          = (c == 0) || (c == 15);
            tick            = (c == 1);
            @(negedge clk);
            chk($sformatf("seq2 c%0d done", c), done, (c == 26) ? 1 : 0);
            if (c == 1)  chk("seq2 s0b0 before swap", word(0), exp_act[0]);
            if (c == 2)  chk("seq2 s0b0 after swap", word(0), 777);
            if (c == 40) chk("seq2 idle at end", busy, 0);
            next();
        end
        wr_if.wrValid_i = 1'b0; commit = 1'b0; tick = 1'b0;
        exp_shd[0] = 18'sd777;
        for (int i = 0; i < NW; i++) exp_act[i] = exp_shd[i];
        check_all("seq2 final");
        chk("seq2 addrErr sticky", aerr, 1);

        // ---- reset in the middle of FLUSH ----
        wr(3, 0, 18'sd100);
        for (int c = 0; c <= 4; c++) begin
            commit = (c == 0);
            tick   = (c == 2);
            rst    = (c == 4);
            @(negedge clk);
            if (c == 4) chk("flush-rst biquadReset", bqrst, 1);
            next();
        end
        rst = 1'b0; commit = 1'b0; tick = 1'b0;
        model_reset();
        @(negedge clk);
        chk("flush-rst busy", busy, 0);
        chk("flush-rst wrReady", wr_if.wrReady_o, 1);
        chk("flush-rst biquadReset", bqrst, 0);
        chk("flush-rst addrErr", aerr, 0);
        check_all("flush-rst");
        next();
        // Shadow must also be passthrough: an empty commit leaves coeff_o unchanged.
        run_commit(2, "post-rst");
        check_all("post-rst commit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
